// File: rtl/mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_if
// Brief    : Control/status bundle for the modulo counter. The master drives
//            the count controls; the slave (counter) returns its state.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_counter_if #(
  parameter int WIDTH = 7
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, load, load_val, clr_ovf,
    input  q, tc, ovf
  );

  modport slave (
    input  en, up, load, load_val, clr_ovf,
    output q, tc, ovf
  );
endinterface
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Brief    : Up/down modulo-MODULUS counter with clamped synchronous load,
//            wrap or saturate at the range ends, a one-cycle terminal-count
//            pulse and a sticky overflow/underflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int WIDTH    = 7,
  parameter int MODULUS  = 100,
  parameter int SATURATE = 0
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mod_counter_if.slave  bus
);

  // Reject a modulus that is below 2 or not representable in WIDTH bits.
  localparam longint c_span = longint'(1) << WIDTH;

  generate
    if ((MODULUS < 2) || (longint'(MODULUS) > c_span)) begin : g_bad_modulus
      $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam int unsigned      c_mod  = MODULUS;
  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next_q;
  logic             w_boundary;
  logic             w_next_ovf;

  // Next count: load (clamped) beats enable; ends of the range are boundary events.
  always_comb begin
    w_next_q   = r_q;
    w_boundary = 1'b0;
    if (bus.load) begin
      // Widen before comparing so a modulus of 2**WIDTH still compares correctly.
      if (32'(bus.load_val) < c_mod) begin
        w_next_q = bus.load_val;
      end else begin
        w_next_q = c_max;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (r_q == c_max) begin
          w_boundary = 1'b1;
          w_next_q   = (SATURATE != 0) ? c_max : c_zero;
        end else begin
          w_next_q = r_q + c_one;
        end
      end else begin
        if (r_q == c_zero) begin
          w_boundary = 1'b1;
          w_next_q   = (SATURATE != 0) ? c_zero : c_max;
        end else begin
          w_next_q = r_q - c_one;
        end
      end
    end
  end

  // Sticky flag: a boundary event in the same cycle overrides a clear request.
  always_comb begin
    w_next_ovf = r_ovf;
    if (w_boundary) begin
      w_next_ovf = 1'b1;
    end else if (bus.clr_ovf) begin
      w_next_ovf = 1'b0;
    end
  end

  // State registers; reset forces everything to zero immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_next_q;
      r_tc  <= w_boundary;
      r_ovf <= w_next_ovf;
    end
  end

  assign bus.q   = r_q;
  assign bus.tc  = r_tc;
  assign bus.ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_counter
// Brief    : Scoreboard bench for mod_counter: wrap (default), saturate and
//            full-range (WIDTH=4, MODULUS=16) instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

  logic clk;
  logic reset;

  mod_counter_if #(.WIDTH(7)) bus0 ();
  mod_counter_if #(.WIDTH(7)) bus1 ();
  mod_counter_if #(.WIDTH(4)) bus2 ();

  mod_counter #(.WIDTH(7), .MODULUS(100), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  mod_counter #(.WIDTH(7), .MODULUS(100), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_w4 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic [6:0] q;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  event chk_ev;

  // Monitor: after every rising edge (or an explicit asynchronous check) pop and compare.
  initial begin : monitor
    exp_t       e;
    logic [6:0] aq;
    logic       atc;
    logic       aovf;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.d)
          0:       begin aq = bus0.q;        atc = bus0.tc; aovf = bus0.ovf; end
          1:       begin aq = bus1.q;        atc = bus1.tc; aovf = bus1.ovf; end
          default: begin aq = {3'b000, bus2.q}; atc = bus2.tc; aovf = bus2.ovf; end
        endcase
        checks++;
        if ($isunknown({aq, atc, aovf}) || aq !== e.q || atc !== e.tc || aovf !== e.ovf) begin
          failures++;
          $display("FAIL %s (dut%0d): got q=%0d tc=%0b ovf=%0b, expected q=%0d tc=%0b ovf=%0b",
                   e.name, e.d, aq, atc, aovf, e.q, e.tc, e.ovf);
        end
      end
    end
  end

  task automatic idle_all();
    bus0.en = 0; bus0.up = 0; bus0.load = 0; bus0.load_val = '0; bus0.clr_ovf = 0;
    bus1.en = 0; bus1.up = 0; bus1.load = 0; bus1.load_val = '0; bus1.clr_ovf = 0;
    bus2.en = 0; bus2.up = 0; bus2.load = 0; bus2.load_val = '0; bus2.clr_ovf = 0;
  endtask

  task automatic push(input int d, input logic [6:0] q, input logic tc, input logic ovf,
                      input string nm);
    exp_t e;
    e.d = d; e.q = q; e.tc = tc; e.ovf = ovf; e.name = nm;
    sb.push_back(e);
  endtask

  // One clock of stimulus on instance d, with its expected post-edge state.
  task automatic step(input int d, input logic en, input logic up, input logic ld,
                      input logic [6:0] lv, input logic clr,
                      input logic [6:0] eq, input logic etc, input logic eovf,
                      input string nm);
    @(negedge clk);
    idle_all();
    case (d)
      0: begin bus0.en = en; bus0.up = up; bus0.load = ld; bus0.load_val = lv; bus0.clr_ovf = clr; end
      1: begin bus1.en = en; bus1.up = up; bus1.load = ld; bus1.load_val = lv; bus1.clr_ovf = clr; end
      default: begin bus2.en = en; bus2.up = up; bus2.load = ld; bus2.load_val = lv[3:0]; bus2.clr_ovf = clr; end
    endcase
    push(d, eq, etc, eovf, nm);
    @(posedge clk);
  endtask

  initial begin : stimulus
    idle_all();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    push(0, 7'd0, 1'b0, 1'b0, "reset_state");
    ->chk_ev;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Full up-count sweep through the wrap.
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, 1, 0, 7'd0, 0, 7'(i % 100), (i == 100), (i == 100), "up_sweep");
    end
    step(0, 0, 0, 0, 7'd0, 0, 7'd0, 0, 1, "hold_after_wrap");

    // Underflow wrap, then clear of the sticky flag.
    step(0, 1, 0, 0, 7'd0, 0, 7'd99, 1, 1, "down_wrap");
    step(0, 0, 0, 0, 7'd0, 1, 7'd99, 0, 0, "clr_ovf");

    // Loads: clamp, priority over enable, modulus edge.
    step(0, 0, 0, 1, 7'd120, 0, 7'd99, 0, 0, "load_clamp_120");
    step(0, 1, 1, 1, 7'd42, 0, 7'd42, 0, 0, "load_over_en");
    step(0, 1, 0, 0, 7'd0, 0, 7'd41, 0, 0, "down_step");
    step(0, 1, 1, 0, 7'd0, 0, 7'd42, 0, 0, "dir_change");
    step(0, 0, 0, 1, 7'd100, 0, 7'd99, 0, 0, "load_clamp_100");
    step(0, 0, 0, 1, 7'd98, 0, 7'd98, 0, 0, "load_98");
    step(0, 1, 1, 0, 7'd0, 0, 7'd99, 0, 0, "up_to_max");

    // Boundary and clear in the same cycle: set wins.
    step(0, 1, 1, 0, 7'd0, 1, 7'd0, 1, 1, "wrap_with_clr");
    step(0, 0, 0, 0, 7'd0, 1, 7'd0, 0, 0, "clr_after");

    // Asynchronous reset mid-cycle discards an in-flight count.
    step(0, 1, 0, 0, 7'd0, 0, 7'd99, 1, 1, "down_wrap2");
    step(0, 0, 0, 1, 7'd57, 0, 7'd57, 0, 1, "load_57");
    @(negedge clk);
    idle_all();
    bus0.en = 1; bus0.up = 1;
    #1 reset = 1'b0;
    push(0, 7'd0, 1'b0, 1'b0, "async_reset");
    ->chk_ev;
    #2 reset = 1'b1;
    push(0, 7'd1, 1'b0, 1'b0, "resume_after_reset");
    @(posedge clk);

    // Saturating instance.
    step(1, 0, 0, 1, 7'd99, 0, 7'd99, 0, 0, "sat_load_99");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 7'd0, 0, 7'd99, 1, 1, "sat_hold_top");
    end
    step(1, 0, 0, 0, 7'd0, 0, 7'd99, 0, 1, "sat_idle");
    step(1, 0, 0, 1, 7'd0, 1, 7'd0, 0, 0, "sat_load_0_clr");
    step(1, 1, 0, 0, 7'd0, 0, 7'd0, 1, 1, "sat_hold_bottom");

    // Full-range instance (MODULUS == 2**WIDTH).
    step(2, 0, 0, 1, 7'd15, 0, 7'd15, 0, 0, "w4_load_15");
    step(2, 1, 1, 0, 7'd0, 0, 7'd0, 1, 1, "w4_wrap_up");
    step(2, 1, 1, 0, 7'd0, 0, 7'd1, 0, 1, "w4_up");
    step(2, 1, 0, 0, 7'd0, 0, 7'd0, 0, 1, "w4_down");
    step(2, 1, 0, 0, 7'd0, 0, 7'd15, 1, 1, "w4_wrap_down");

    @(negedge clk);
    idle_all();
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 7: counter width in bits.
REQ-002 Parameter MODULUS, default 100: count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH. Out-of-range values shall stop elaboration with an error.
REQ-003 Parameter SATURATE, default 0: 0 means wrap at the boundary, 1 means hold at the boundary.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered terminal-count pulse.
REQ-013 ovf  output  1  registered sticky overflow/underflow flag.

Function
REQ-014 Priority each cycle: load over en. With load high, en and up are ignored for q.
REQ-015 Load: q takes load_val on the next edge if load_val < MODULUS, otherwise MODULUS-1 (clamp). A load shall not assert tc or set ovf.
REQ-016 Up count (en=1, up=1, load=0), q < MODULUS-1: q becomes q+1.
REQ-017 Up count at q == MODULUS-1 is a boundary event:
- SATURATE=0: q becomes 0.
- SATURATE=1: q holds at MODULUS-1.
REQ-018 Down count (en=1, up=0, load=0), q > 0: q becomes q-1.
REQ-019 Down count at q == 0 is a boundary event:
- SATURATE=0: q becomes MODULUS-1.
- SATURATE=1: q holds at 0.
REQ-020 en=0 and load=0: q holds.
REQ-021 tc is high for exactly the one cycle following each boundary event, coincident with q showing the post-event value; otherwise tc is low. Back-to-back boundary events keep tc high continuously.
REQ-022 ovf is set on the edge of any boundary event and stays set until cleared.
REQ-023 clr_ovf=1 clears ovf on the next edge, except when a boundary event occurs in the same cycle; then set wins and ovf stays 1.
REQ-024 Arithmetic is performed in WIDTH bits. Boundary detection compares against MODULUS-1 and 0, so q never leaves 0..MODULUS-1, including when MODULUS == 2**WIDTH.
REQ-025 A change of up between cycles takes effect on the next edge; there is no direction-change latency.

Reset
REQ-026 reset low shall immediately and asynchronously force q=0, tc=0 and ovf=0, independent of clk.
REQ-027 While reset is low, all inputs are ignored.
REQ-028 Reset asserted during a count or load discards that operation.
REQ-029 On the first rising edge after reset deasserts, normal operation resumes from q=0.

Verification
REQ-030 Default parameters, reset low for 2 cycles, then en=1, up=1 for 100 cycles -> q steps 0..99 then returns to 0; tc high only in the cycle q=0 follows q=99; ovf=1 afterwards.
REQ-031 q=0, en=1, up=0 -> q=99 next cycle with tc=1 and ovf=1. Then clr_ovf=1 for one cycle -> ovf=0.
REQ-032 load=1, load_val=120 -> q=99 with no tc. Then load=1, load_val=42 with en=1 in the same cycle -> q=42.
REQ-033 SATURATE=1, load 99, up count for 3 cycles -> q stays 99; tc high for 3 consecutive cycles; ovf=1.
REQ-034 q=99, en=1, up=1, clr_ovf=1 in the same cycle -> q=0, ovf stays 1.
REQ-035 reset pulsed low mid-cycle while q=57 -> q=0, tc=0, ovf=0 before the next clk edge; counting resumes from 0.
REQ-036 WIDTH=4, MODULUS=16, up count from 15 -> q=0, tc=1; no X or out-of-range values observed.
